// File: rtl/btb_ctrl.sv
// BTB write-side controller.
// After reset or a flush it invalidates every BTB set, one set per cycle. Otherwise it
// accepts resolved branches from EX and queues BTB writes for mispredicted branches only.
// The queue drains one write per cycle, in order. It also keeps a saturating count of
// mispredicts.
module btb_ctrl #(
  parameter int unsigned SET_ADDR_LEN = 12,
  parameter int unsigned TAG_ADDR_LEN = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    upd_valid,
  input  logic [31:0]             upd_pc,
  input  logic [31:0]             upd_target,
  input  logic                    upd_taken,
  input  logic                    upd_pred_take,
  output logic                    upd_ready,
  input  logic                    flush_req,
  output logic                    busy,
  output logic                    wr_en,
  output logic [SET_ADDR_LEN-1:0] wr_set,
  output logic [TAG_ADDR_LEN-1:0] wr_tag,
  output logic [31:0]             wr_target,
  output logic                    wr_valid,
  output logic [15:0]             mispred_cnt
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [SET_ADDR_LEN-1:0] LastSet = '1;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e                  state_q, state_d;
  logic [SET_ADDR_LEN-1:0] clr_idx_q, clr_idx_d;
  logic [PtrW:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [15:0]             cnt_q, cnt_d;

  logic [SET_ADDR_LEN-1:0] fifo_set_q    [FIFO_DEPTH];
  logic [TAG_ADDR_LEN-1:0] fifo_tag_q    [FIFO_DEPTH];
  logic [31:0]             fifo_target_q [FIFO_DEPTH];
  logic                    fifo_valid_q  [FIFO_DEPTH];

  logic                    fifo_full, fifo_empty;
  logic                    accept, mispred, enq, deq;
  logic [SET_ADDR_LEN-1:0] upd_set;
  logic [TAG_ADDR_LEN-1:0] upd_tag;
  logic [PtrW-1:0]         head_idx;

  assign upd_set  = upd_pc[SET_ADDR_LEN+1:2];
  assign upd_tag  = upd_pc[TAG_ADDR_LEN+SET_ADDR_LEN+1:SET_ADDR_LEN+2];
  assign head_idx = rptr_q[PtrW-1:0];

  // The PC bits above the tag and the byte-offset bits take no part in set/tag.
  if (TAG_ADDR_LEN + SET_ADDR_LEN + 2 < 32) begin : g_pc_hi
    logic unused_pc_hi;
    assign unused_pc_hi = ^upd_pc[31:TAG_ADDR_LEN+SET_ADDR_LEN+2];
  end
  logic unused_pc_lo;
  assign unused_pc_lo = ^upd_pc[1:0];

  // The extra pointer bit tells a full queue apart from an empty one.
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                      (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);

  assign accept      = upd_valid & upd_ready;
  assign mispred     = upd_taken ^ upd_pred_take;
  assign deq         = !rst && (state_q == StRun) && !fifo_empty;
  assign mispred_cnt = cnt_q;

  // Outputs: forced idle while in reset; clear writes in CLEAR; queue head in RUN.
  always_comb begin
    busy      = 1'b0;
    upd_ready = 1'b0;
    wr_en     = 1'b0;
    wr_set    = '0;
    wr_tag    = '0;
    wr_target = '0;
    wr_valid  = 1'b0;
    if (rst) begin
      busy = 1'b1;
    end else if (state_q == StClear) begin
      busy   = 1'b1;
      wr_en  = 1'b1;
      wr_set = clr_idx_q;
    end else begin
      upd_ready = !fifo_full;
      if (!fifo_empty) begin
        wr_en     = 1'b1;
        wr_set    = fifo_set_q[head_idx];
        wr_tag    = fifo_tag_q[head_idx];
        wr_target = fifo_target_q[head_idx];
        wr_valid  = fifo_valid_q[head_idx];
      end
    end
  end

  // Next state: clear sweep, queue pointers and the saturating mispredict counter.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    enq       = 1'b0;

    // A mispredict accepted in a flush cycle still counts, even though its write is dropped.
    if (accept && mispred && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;

    unique case (state_q)
      StClear: begin
        // A flush request here is ignored; the sweep runs to the last set.
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LastSet) state_d = StRun;
      end
      StRun: begin
        if (flush_req) begin
          state_d   = StClear;
          clr_idx_d = '0;
          rptr_d    = wptr_q;
        end else begin
          enq = accept && mispred;
          if (enq) wptr_d = wptr_q + 1'b1;
          if (deq) rptr_d = rptr_q + 1'b1;
        end
      end
      default: state_d = StClear;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Queue storage. Entries need no reset because the pointers decide validity.
  // A taken branch installs its target; a not-taken branch writes an invalid entry.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_set_q[wptr_q[PtrW-1:0]]    <= upd_set;
      fifo_tag_q[wptr_q[PtrW-1:0]]    <= upd_tag;
      fifo_target_q[wptr_q[PtrW-1:0]] <= upd_taken ? upd_target : 32'd0;
      fifo_valid_q[wptr_q[PtrW-1:0]]  <= upd_taken;
    end
  end

endmodule

// File: tb/tb_btb_ctrl.sv
// Directed self-checking bench for btb_ctrl (8 sets, 1-bit tag, 4-entry queue).
module tb_btb_ctrl;

  logic        clk;
  logic        rst;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_pred_take;
  logic        upd_ready;
  logic        flush_req;
  logic        busy;
  logic        wr_en;
  logic [2:0]  wr_set;
  logic [0:0]  wr_tag;
  logic [31:0] wr_target;
  logic        wr_valid;
  logic [15:0] mispred_cnt;

  int checks   = 0;
  int failures = 0;

  btb_ctrl #(
    .SET_ADDR_LEN(3),
    .TAG_ADDR_LEN(1),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .upd_taken    (upd_taken),
    .upd_pred_take(upd_pred_take),
    .upd_ready    (upd_ready),
    .flush_req    (flush_req),
    .busy         (busy),
    .wr_en        (wr_en),
    .wr_set       (wr_set),
    .wr_tag       (wr_tag),
    .wr_target    (wr_target),
    .wr_valid     (wr_valid),
    .mispred_cnt  (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic tk, input logic pr);
    upd_valid     = v;
    upd_pc        = pc;
    upd_target    = tgt;
    upd_taken     = tk;
    upd_pred_take = pr;
  endtask

  // Hand-derived set = pc[4:2], tag = pc[5] for the burst vectors.
  logic [31:0] burst_pc  [5] = '{32'h00, 32'h24, 32'h28, 32'h3C, 32'h30};
  logic [2:0]  burst_set [5] = '{3'd0, 3'd1, 3'd2, 3'd7, 3'd4};
  logic [0:0]  burst_tag [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    rst       = 1'b1;
    flush_req = 1'b0;
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Outputs held idle during reset.
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_ready", {31'd0, upd_ready}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_set", {29'd0, wr_set}, 32'd0);
    chk("rst_cnt", {16'd0, mispred_cnt}, 32'd0);
    tick();

    // Clear sweep after release: 8 cycles, sets 0..7, invalid writes.
    rst = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("clr_busy", {31'd0, busy}, 32'd1);
      chk("clr_wr_en", {31'd0, wr_en}, 32'd1);
      chk("clr_wr_set", {29'd0, wr_set}, i);
      chk("clr_wr_valid", {31'd0, wr_valid}, 32'd0);
      chk("clr_ready", {31'd0, upd_ready}, 32'd0);
      tick();
    end
    chk("run_busy", {31'd0, busy}, 32'd0);
    chk("run_ready", {31'd0, upd_ready}, 32'd1);
    chk("run_wr_en", {31'd0, wr_en}, 32'd0);
    chk("run_cnt", {16'd0, mispred_cnt}, 32'd0);

    // Taken but predicted not-taken: pc 0x24 -> set 1, tag 1, valid entry.
    set_upd(1'b1, 32'h24, 32'h100, 1'b1, 1'b0);
    tick();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("t1_wr_en", {31'd0, wr_en}, 32'd1);
    chk("t1_wr_set", {29'd0, wr_set}, 32'd1);
    chk("t1_wr_tag", {31'd0, wr_tag}, 32'd1);
    chk("t1_wr_target", wr_target, 32'h100);
    chk("t1_wr_valid", {31'd0, wr_valid}, 32'd1);
    chk("t1_cnt", {16'd0, mispred_cnt}, 32'd1);
    tick();
    chk("t1_drained", {31'd0, wr_en}, 32'd0);
    chk("t1_idle_target", wr_target, 32'd0);

    // Not taken but predicted taken: pc 0x3C -> set 7, tag 1, invalidating write.
    set_upd(1'b1, 32'h3C, 32'h55, 1'b0, 1'b1);
    tick();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("t2_wr_en", {31'd0, wr_en}, 32'd1);
    chk("t2_wr_set", {29'd0, wr_set}, 32'd7);
    chk("t2_wr_tag", {31'd0, wr_tag}, 32'd1);
    chk("t2_wr_valid", {31'd0, wr_valid}, 32'd0);
    chk("t2_wr_target", wr_target, 32'd0);
    chk("t2_cnt", {16'd0, mispred_cnt}, 32'd2);

    // Correct prediction is consumed with no write and no count.
    set_upd(1'b1, 32'h08, 32'h80, 1'b1, 1'b1);
    tick();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("t3_wr_en", {31'd0, wr_en}, 32'd0);
    chk("t3_cnt", {16'd0, mispred_cnt}, 32'd2);

    // Five back-to-back mispredicts: ready stays high, writes follow in order.
    for (int i = 0; i < 5; i++) begin
      set_upd(1'b1, burst_pc[i], 32'h200 + i, 1'b1, 1'b0);
      #1;
      chk("b_ready", {31'd0, upd_ready}, 32'd1);
      if (i > 0) begin
        chk("b_wr_en", {31'd0, wr_en}, 32'd1);
        chk("b_wr_set", {29'd0, wr_set}, {29'd0, burst_set[i-1]});
        chk("b_wr_tag", {31'd0, wr_tag}, {31'd0, burst_tag[i-1]});
        chk("b_wr_target", wr_target, 32'h200 + i - 1);
      end
      tick();
    end
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("b_last_set", {29'd0, wr_set}, 32'd4);
    chk("b_last_target", wr_target, 32'h204);
    chk("b_cnt", {16'd0, mispred_cnt}, 32'd7);
    tick();
    chk("b_drained", {31'd0, wr_en}, 32'd0);

    // Flush with a same-cycle mispredict: counted, never written.
    set_upd(1'b1, 32'h10, 32'h300, 1'b1, 1'b0);
    flush_req = 1'b1;
    tick();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    flush_req = 1'b0;
    #1;
    chk("f_cnt", {16'd0, mispred_cnt}, 32'd8);
    for (int i = 0; i < 8; i++) begin
      flush_req = (i == 4);
      #1;
      chk("f_busy", {31'd0, busy}, 32'd1);
      chk("f_wr_set", {29'd0, wr_set}, i);
      chk("f_wr_valid", {31'd0, wr_valid}, 32'd0);
      chk("f_wr_target", wr_target, 32'd0);
      tick();
    end
    flush_req = 1'b0;
    #1;
    chk("f_done_busy", {31'd0, busy}, 32'd0);
    chk("f_discarded", {31'd0, wr_en}, 32'd0);

    // Saturation: 65527 more mispredicts reach 0xFFFF, one more holds it.
    set_upd(1'b1, 32'h04, 32'h400, 1'b1, 1'b0);
    repeat (65527) @(posedge clk);
    #1;
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("s_max", {16'd0, mispred_cnt}, 32'hFFFF);
    set_upd(1'b1, 32'h04, 32'h400, 1'b0, 1'b1);
    tick();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("s_hold", {16'd0, mispred_cnt}, 32'hFFFF);
    tick();

    // Reset mid-RUN with a pending write: outputs idle, clear restarts, write lost.
    set_upd(1'b1, 32'h14, 32'h500, 1'b1, 1'b0);
    tick();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("r_wr_en", {31'd0, wr_en}, 32'd0);
    chk("r_busy", {31'd0, busy}, 32'd1);
    chk("r_ready", {31'd0, upd_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("r_wr_set0", {29'd0, wr_set}, 32'd0);
    chk("r_cnt", {16'd0, mispred_cnt}, 32'd0);
    tick();
    tick();
    tick();
    chk("r_wr_set3", {29'd0, wr_set}, 32'd3);

    // Reset mid-CLEAR restarts the sweep from set 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rc_wr_set0", {29'd0, wr_set}, 32'd0);
    repeat (8) tick();
    chk("rc_busy", {31'd0, busy}, 32'd0);
    chk("rc_lost", {31'd0, wr_en}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
